// File: rtl/snd_cmd_latch_ctrl.sv
// Controller in front of the 74373 sound-command latch: synchronises the CPU strobes,
// registers the command byte, sequences latch C / OCn and tracks pending + overruns.
module snd_cmd_latch_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int STROBE_LEN  = 2,
    parameter int OVR_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_wr_n,
    input  logic [7:0]       cpu_d,
    input  logic             snd_rd_n,
    output logic [7:0]       latch_d,
    output logic             latch_c,
    output logic             latch_ocn,
    output logic             pending,
    output logic             snd_nmi,
    output logic [OVR_W-1:0] ovr_cnt
);

    localparam int CNT_W = $clog2(STROBE_LEN + 1);
    localparam logic [CNT_W-1:0] LEN = CNT_W'(STROBE_LEN);

    typedef enum logic [1:0] {IDLE, STROBE, PEND, READ} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] wr_sync;
    logic [SYNC_STAGES-1:0] rd_sync;
    logic                   wr_hist;
    logic                   rd_hist;
    logic [CNT_W-1:0]       len_cnt;
    logic [7:0]             shadow;
    logic                   deferred;
    logic                   wr_rise;
    logic                   rd_fall;
    logic                   rd_rise;
    logic                   ovr_full;

    // Both strobes idle high, so the synchronisers reset to ones to avoid a false edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_sync <= '1;
            rd_sync <= '1;
            wr_hist <= 1'b1;
            rd_hist <= 1'b1;
        end else begin
            wr_sync <= {wr_sync[SYNC_STAGES-2:0], cpu_wr_n};
            rd_sync <= {rd_sync[SYNC_STAGES-2:0], snd_rd_n};
            wr_hist <= wr_sync[SYNC_STAGES-1];
            rd_hist <= rd_sync[SYNC_STAGES-1];
        end
    end

    assign wr_rise  = !wr_hist && wr_sync[SYNC_STAGES-1];
    assign rd_fall  = rd_hist && !rd_sync[SYNC_STAGES-1];
    assign rd_rise  = !rd_hist && rd_sync[SYNC_STAGES-1];
    assign ovr_full = (ovr_cnt == {OVR_W{1'b1}});
    assign snd_nmi  = pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            latch_d   <= 8'h00;
            latch_c   <= 1'b0;
            latch_ocn <= 1'b1;
            pending   <= 1'b0;
            ovr_cnt   <= '0;
            len_cnt   <= '0;
            shadow    <= 8'h00;
            deferred  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_rise) begin
                        latch_d <= cpu_d;
                        len_cnt <= '0;
                        state   <= STROBE;
                    end
                end
                STROBE: begin
                    if (wr_rise) begin
                        latch_d <= cpu_d;
                        latch_c <= 1'b0;
                        len_cnt <= '0;
                        if (!ovr_full) ovr_cnt <= ovr_cnt + OVR_W'(1);
                    end else if (len_cnt != LEN) begin
                        latch_c <= 1'b1;
                        len_cnt <= len_cnt + CNT_W'(1);
                    end else begin
                        latch_c <= 1'b0;
                        pending <= 1'b1;
                        state   <= PEND;
                    end
                end
                // A write colliding with a read edge wins; the sound CPU re-reads on NMI.
                PEND: begin
                    if (wr_rise) begin
                        latch_d <= cpu_d;
                        len_cnt <= '0;
                        state   <= STROBE;
                        if (!ovr_full) ovr_cnt <= ovr_cnt + OVR_W'(1);
                    end else if (rd_fall) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (rd_rise) begin
                        latch_ocn <= 1'b1;
                        if (deferred || wr_rise) begin
                            latch_d  <= wr_rise ? cpu_d : shadow;
                            deferred <= 1'b0;
                            len_cnt  <= '0;
                            state    <= STROBE;
                        end else begin
                            pending <= 1'b0;
                            state   <= IDLE;
                        end
                    end else begin
                        latch_ocn <= 1'b0;
                        if (wr_rise) begin
                            shadow   <= cpu_d;
                            deferred <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snd_cmd_latch_ctrl.sv
// Directed bench for snd_cmd_latch_ctrl with cycle-exact expectations
// plus a randomised strobe phase guarding C / OCn exclusivity.
module tb_snd_cmd_latch_ctrl;

    logic       clk;
    logic       reset;
    logic       cpu_wr_n;
    logic [7:0] cpu_d;
    logic       snd_rd_n;
    logic [7:0] latch_d;
    logic       latch_c;
    logic       latch_ocn;
    logic       pending;
    logic       snd_nmi;
    logic [3:0] ovr_cnt;
    logic       mon_en;
    int         checks;
    int         errors;

    snd_cmd_latch_ctrl #(.SYNC_STAGES(2), .STROBE_LEN(2), .OVR_W(4)) dut (
        .clk(clk), .reset(reset), .cpu_wr_n(cpu_wr_n), .cpu_d(cpu_d), .snd_rd_n(snd_rd_n),
        .latch_d(latch_d), .latch_c(latch_c), .latch_ocn(latch_ocn),
        .pending(pending), .snd_nmi(snd_nmi), .ovr_cnt(ovr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write strobe: low for three cycles, then released; leaves cpu_d stable.
    task automatic applyStimulus(input logic [7:0] data);
        cpu_d    = data;
        cpu_wr_n = 1'b0;
        step(3);
        cpu_wr_n = 1'b1;
    endtask

    task automatic writeFull(input logic [7:0] data);
        applyStimulus(data);
        step(6);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_latch_d"}, latch_d, 8'h00);
        checkOutput({tag, "_latch_c"}, 8'(latch_c), 8'h00);
        checkOutput({tag, "_latch_ocn"}, 8'(latch_ocn), 8'h01);
        checkOutput({tag, "_pending"}, 8'(pending), 8'h00);
        checkOutput({tag, "_snd_nmi"}, 8'(snd_nmi), 8'h00);
        checkOutput({tag, "_ovr_cnt"}, 8'(ovr_cnt), 8'h00);
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            checks++;
            assert ((latch_c && !latch_ocn) === 1'b0)
            else begin
                errors++;
                $error("[TB] FAIL c_ocn_overlap: observed latch_c=%0b latch_ocn=%0b expected not both active",
                       latch_c, latch_ocn);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        cpu_wr_n = 1'b1;
        snd_rd_n = 1'b1;
        cpu_d    = 8'h00;
        mon_en   = 1'b0;
        checks   = 0;
        errors   = 0;
        step(2);
        checkResetValues("por");
        reset  = 1'b0;
        mon_en = 1'b1;
        step(2);

        $display("[TB] single command");
        applyStimulus(8'hA5);
        step(3);
        checkOutput("t2_capture_d", latch_d, 8'hA5);
        checkOutput("t2_c_before", 8'(latch_c), 8'h00);
        step(1);
        checkOutput("t2_c_first", 8'(latch_c), 8'h01);
        checkOutput("t2_pend_early", 8'(pending), 8'h00);
        step(1);
        checkOutput("t2_c_second", 8'(latch_c), 8'h01);
        step(1);
        checkOutput("t2_c_end", 8'(latch_c), 8'h00);
        checkOutput("t2_pending", 8'(pending), 8'h01);
        checkOutput("t2_nmi", 8'(snd_nmi), 8'h01);
        snd_rd_n = 1'b0;
        step(3);
        checkOutput("t2_ocn_lat3", 8'(latch_ocn), 8'h01);
        step(1);
        checkOutput("t2_ocn_lat4", 8'(latch_ocn), 8'h00);
        checkOutput("t2_pend_in_read", 8'(pending), 8'h01);
        step(2);
        snd_rd_n = 1'b1;
        step(2);
        checkOutput("t2_ocn_hold", 8'(latch_ocn), 8'h00);
        step(1);
        checkOutput("t2_ocn_release", 8'(latch_ocn), 8'h01);
        checkOutput("t2_pend_clear", 8'(pending), 8'h00);
        step(2);

        $display("[TB] overrun");
        writeFull(8'h11);
        checkOutput("t3_first_d", latch_d, 8'h11);
        checkOutput("t3_first_ovr", 8'(ovr_cnt), 8'h00);
        applyStimulus(8'h22);
        step(3);
        checkOutput("t3_second_d", latch_d, 8'h22);
        checkOutput("t3_ovr_one", 8'(ovr_cnt), 8'h01);
        step(1);
        checkOutput("t3_second_c", 8'(latch_c), 8'h01);
        step(2);
        checkOutput("t3_second_c_end", 8'(latch_c), 8'h00);
        checkOutput("t3_pending", 8'(pending), 8'h01);
        for (int i = 0; i < 13; i++) writeFull(8'(8'h30 + i));
        checkOutput("t3_ovr_14", 8'(ovr_cnt), 8'h0E);
        for (int i = 0; i < 4; i++) writeFull(8'(8'h50 + i));
        checkOutput("t3_ovr_sat", 8'(ovr_cnt), 8'h0F);
        checkOutput("t3_last_d", latch_d, 8'h53);

        $display("[TB] reset mid strobe");
        applyStimulus(8'h66);
        step(4);
        checkOutput("t1_c_active", 8'(latch_c), 8'h01);
        checkOutput("t1_ovr_held", 8'(ovr_cnt), 8'h0F);
        #2;
        reset = 1'b1;
        #1;
        checkResetValues("t1_async");
        step(1);
        reset = 1'b0;
        step(3);
        checkOutput("t1_c_after", 8'(latch_c), 8'h00);
        checkOutput("t1_pend_after", 8'(pending), 8'h00);

        $display("[TB] write during read");
        writeFull(8'h44);
        snd_rd_n = 1'b0;
        step(4);
        checkOutput("t4_ocn_low", 8'(latch_ocn), 8'h00);
        applyStimulus(8'h33);
        step(4);
        checkOutput("t4_no_c", 8'(latch_c), 8'h00);
        checkOutput("t4_d_held", latch_d, 8'h44);
        checkOutput("t4_ocn_still", 8'(latch_ocn), 8'h00);
        snd_rd_n = 1'b1;
        step(3);
        checkOutput("t4_deferred_d", latch_d, 8'h33);
        checkOutput("t4_ocn_high", 8'(latch_ocn), 8'h01);
        checkOutput("t4_pend_kept", 8'(pending), 8'h01);
        step(1);
        checkOutput("t4_c_pulse", 8'(latch_c), 8'h01);
        step(2);
        checkOutput("t4_c_end", 8'(latch_c), 8'h00);
        checkOutput("t4_ovr_zero", 8'(ovr_cnt), 8'h00);

        $display("[TB] collision");
        cpu_d    = 8'h55;
        cpu_wr_n = 1'b0;
        step(3);
        cpu_wr_n = 1'b1;
        snd_rd_n = 1'b0;
        step(3);
        checkOutput("t5_d", latch_d, 8'h55);
        checkOutput("t5_ovr", 8'(ovr_cnt), 8'h01);
        checkOutput("t5_ocn", 8'(latch_ocn), 8'h01);
        step(1);
        checkOutput("t5_c", 8'(latch_c), 8'h01);
        step(4);
        checkOutput("t5_ocn_ignored", 8'(latch_ocn), 8'h01);
        checkOutput("t5_pending", 8'(pending), 8'h01);
        snd_rd_n = 1'b1;
        step(3);
        snd_rd_n = 1'b0;
        step(4);
        checkOutput("t5_reread_ocn", 8'(latch_ocn), 8'h00);
        snd_rd_n = 1'b1;
        step(3);
        checkOutput("t5_reread_done", 8'(pending), 8'h00);

        $display("[TB] spurious read");
        snd_rd_n = 1'b0;
        step(5);
        checkOutput("t6_ocn", 8'(latch_ocn), 8'h01);
        checkOutput("t6_pending", 8'(pending), 8'h00);
        snd_rd_n = 1'b1;
        step(3);
        checkOutput("t6_ocn_after", 8'(latch_ocn), 8'h01);

        $display("[TB] randomised strobes");
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    #($urandom_range(40, 90));
                    cpu_d    = 8'($urandom);
                    cpu_wr_n = 1'b0;
                    #($urandom_range(25, 60));
                    cpu_wr_n = 1'b1;
                end
            end
            begin
                for (int j = 0; j < 25; j++) begin
                    #($urandom_range(1, 80));
                    snd_rd_n = 1'b0;
                    #($urandom_range(25, 60));
                    snd_rd_n = 1'b1;
                end
            end
        join
        step(20);
        checkOutput("rand_settle_ocn", 8'(latch_ocn), 8'h01);
        checkOutput("rand_settle_c", 8'(latch_c), 8'h00);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
